fetch_queue: RTL and testbench

- Instruction fetch stage sitting directly upstream of the ARM control unit.
- Generates word addresses for the RAM instruction read port.
- Captures the synchronous-read data into a small prefetch FIFO.
- Presents instructions, with their PC, to decode over a valid/ready handshake. Branch/PC-write redirects from the control unit flush the queue and restart fetch at the new PC.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues word addresses to a synchronous-read RAM,
// captures the returning words in a small prefetch FIFO, and presents them
// with their PC to decode.
//
// Handshake: instr_valid/instr_ready follow strict valid/ready semantics.
// A transfer happens on a rising edge where both are high. While instr_valid
// is high and instr_ready is low, instr and instr_pc stay stable. instr_valid
// never depends on instr_ready. A redirect gates instr_valid low, so no
// transfer happens in a redirect cycle.
module fetch_queue #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);
  localparam logic [LVL_W:0]    DEPTH_L    = (LVL_W+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // FIFO storage is deliberately not reset; the head is only observed while valid.
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic [LVL_W:0] occupancy;
  logic           issue;
  logic           wr_en;
  logic           pop;

  // Issue/accept decisions. Counting the in-flight read against the depth
  // guarantees the returning word always finds a free slot.
  always_comb begin
    occupancy   = {1'b0, level_q} + (LVL_W+1)'(inflight_q);
    issue       = rst_n & ~redirect & (occupancy < DEPTH_L);
    wr_en       = inflight_q & ~redirect;
    instr_valid = (level_q != '0) & ~redirect;
    pop         = instr_valid & instr_ready;
  end

  // Next-state: redirect flushes everything and reloads the fetch PC.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = inflight_q;
    head_d        = head_q;
    tail_d        = tail_q;
    level_d       = level_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      level_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 1'b1;
      end
      if (wr_en) tail_d = tail_q + 1'b1;
      if (pop)   head_d = head_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC_L;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      level_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      level_q       <= level_d;
    end
  end

  // FIFO write of the returning RAM word tagged with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem_q[tail_q] <= imem_data;
      pc_mem_q[tail_q]   <= inflight_pc_q;
    end
  end

  // Output mapping.
  always_comb begin
    imem_addr = fetch_pc_q;
    imem_en   = issue;
    instr     = data_mem_q[head_q];
    instr_pc  = pc_mem_q[head_q];
    level     = level_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a synchronous-read RAM model feeds the
// fetch port; expected PCs and instruction words are computed by hand.
module tb_fetch_queue;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [DATA_W-1:0] imem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [LVL_W-1:0]  level;

  int checks;
  int failures;
  int pop_cnt;
  int pops_before;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_pc;

  fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_en(imem_en),
    .imem_data(imem_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .level(level)
  );

  // Clock: posedges at 5,15,...; inputs driven and outputs checked near negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word k holds 0xE0000000 + k, read data one edge after issue.
  logic [DATA_W-1:0] ram [1 << ADDR_W];
  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = 32'hE000_0000 + DATA_W'(k);
  end
  always @(posedge clk) begin
    if (imem_en) imem_data <= ram[imem_addr];
  end

  // Count accepted instructions.
  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) pop_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; pop_cnt = 0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset state
    cyc(); #1;
    check("rst_valid", instr_valid, 0);
    check("rst_en", imem_en, 0);
    check("rst_level", level, 0);
    check("rst_addr", imem_addr, 0);
    cyc(); cyc();

    // 1: first instruction two edges after release, then one per cycle
    cyc(); rst_n = 1'b1; #1;
    check("t1_en0", imem_en, 1);
    check("t1_addr0", imem_addr, 0);
    check("t1_valid0", instr_valid, 0);
    cyc(); #1;
    check("t1_valid1", instr_valid, 0);
    check("t1_addr1", imem_addr, 1);
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      check("t1_valid", instr_valid, 1);
      check("t1_pc", instr_pc, k);
      check("t1_instr", instr, 32'hE000_0000 + k);
      if (k == 2) check("t1_level", level, 1);
    end

    // 2: backpressure fills the queue, then drains without loss
    cyc(); rst_n = 1'b0; instr_ready = 1'b0;
    cyc(); cyc(); rst_n = 1'b1;
    repeat (4) cyc(); #1;
    check("t2_en_stop", imem_en, 0);
    check("t2_level3", level, 3);
    repeat (6) cyc(); #1;
    check("t2_level4", level, 4);
    check("t2_en_full", imem_en, 0);
    check("t2_addr", imem_addr, 4);
    check("t2_valid", instr_valid, 1);
    check("t2_hold_pc", instr_pc, 0);
    check("t2_hold_instr", instr, 32'hE000_0000);
    for (int k = 0; k < 8; k++) exp_q.push_back(ADDR_W'(k));
    instr_ready = 1'b1;
    while (exp_q.size() != 0) begin
      exp_pc = exp_q.pop_front();
      check("t2_drain_valid", instr_valid, 1);
      check("t2_drain_pc", instr_pc, exp_pc);
      check("t2_drain_instr", instr, 32'hE000_0000 + exp_pc);
      cyc(); #1;
    end

    // 3: redirect with three entries queued and a read in flight
    instr_ready = 1'b0;
    cyc(); #1;
    check("t3_level3", level, 3);
    check("t3_head", instr_pc, 8);
    redirect = 1'b1; redirect_pc = 6'd20; #1;
    check("t3_valid_gate", instr_valid, 0);
    check("t3_en_gate", imem_en, 0);
    cyc(); redirect = 1'b0; instr_ready = 1'b1; #1;
    check("t3_level0", level, 0);
    check("t3_valid_post", instr_valid, 0);
    check("t3_en", imem_en, 1);
    check("t3_addr", imem_addr, 20);
    cyc(); #1;
    check("t3_valid_lat", instr_valid, 0);
    check("t3_addr21", imem_addr, 21);
    cyc(); #1;
    check("t3_valid", instr_valid, 1);
    check("t3_pc20", instr_pc, 20);
    check("t3_instr20", instr, 32'hE000_0014);
    cyc(); #1;
    check("t3_pc21", instr_pc, 21);

    // 4: redirect and ready in the same cycle with a valid head
    check("t4_level", level, 1);
    pops_before = pop_cnt;
    redirect = 1'b1; redirect_pc = 6'd40; #1;
    check("t4_valid_gate", instr_valid, 0);
    cyc(); redirect = 1'b0; #1;
    check("t4_no_pop", pop_cnt, pops_before);
    check("t4_level0", level, 0);
    check("t4_addr", imem_addr, 40);
    cyc(); cyc(); #1;
    check("t4_pc40", instr_pc, 40);
    check("t4_valid", instr_valid, 1);
    cyc(); #1;
    check("t4_pc41", instr_pc, 41);

    // 5: address wrap 62, 63, 0, 1
    redirect = 1'b1; redirect_pc = 6'd62;
    cyc(); redirect = 1'b0; #1;
    check("t5_addr62", imem_addr, 62);
    cyc(); #1;
    check("t5_addr63", imem_addr, 63);
    cyc(); #1;
    check("t5_addr_wrap", imem_addr, 0);
    check("t5_pc62", instr_pc, 62);
    cyc(); #1;
    check("t5_pc63", instr_pc, 63);
    check("t5_instr63", instr, 32'hE000_003F);
    cyc(); #1;
    check("t5_pc0", instr_pc, 0);
    check("t5_instr0", instr, 32'hE000_0000);
    cyc(); #1;
    check("t5_pc1", instr_pc, 1);

    // 6: asynchronous reset mid-stream with two entries queued
    cyc(); instr_ready = 1'b0;
    cyc(); #1;
    check("t6_level2", level, 2);
    check("t6_head", instr_pc, 2);
    #2 rst_n = 1'b0; #1;
    check("t6_async_valid", instr_valid, 0);
    check("t6_async_level", level, 0);
    check("t6_async_en", imem_en, 0);
    check("t6_async_addr", imem_addr, 0);
    cyc(); cyc(); rst_n = 1'b1; instr_ready = 1'b1; #1;
    check("t6_restart_addr", imem_addr, 0);
    check("t6_restart_en", imem_en, 1);
    cyc(); #1;
    check("t6_valid_lat", instr_valid, 0);
    cyc(); #1;
    check("t6_valid", instr_valid, 1);
    check("t6_pc0", instr_pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
